// File: rtl/fetch_stall_unit_if.sv
// Fetch-stage bus: hazard/branch requests and instruction memory into the fetch
// unit; PC, IF/ID contents and pipeline enables out of it.
interface fetch_stall_unit_if;
  logic        StallReq;
  logic        FlushReq;
  logic [31:0] BranchTarget;
  logic [31:0] InstrIn;
  logic [31:0] PCOut;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCPlus4;
  logic        IFIDValid;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        BubbleOut;
  logic        StallTimeout;
  logic [31:0] StallCount;

  modport master (
    output StallReq, FlushReq, BranchTarget, InstrIn,
    input  PCOut, IFIDInstr, IFIDPCPlus4, IFIDValid,
    input  PCWrite, IFIDWrite, BubbleOut, StallTimeout, StallCount
  );

  modport slave (
    input  StallReq, FlushReq, BranchTarget, InstrIn,
    output PCOut, IFIDInstr, IFIDPCPlus4, IFIDValid,
    output PCWrite, IFIDWrite, BubbleOut, StallTimeout, StallCount
  );
endinterface

// File: rtl/fetch_stall_unit.sv
// PC + IF/ID owner responding to hazard stalls and branch flushes, with a
// post-reset warm-up window. Optional stall counter: define STALL_PERF_EN.
module fetch_stall_unit #(
  parameter int          WARMUP_CYCLES = 4,
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int          MAX_STALL     = 15
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  fetch_stall_unit_if.slave    bus
);
  localparam int SCW   = $clog2(MAX_STALL + 1);
  localparam int WW    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int WINIT = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {WARM, RUN, STALL} state_t;

  state_t           state, state_nxt;
  logic [WW-1:0]    warm_cnt, warm_nxt;
  logic [SCW-1:0]   scnt, scnt_nxt;
  logic             to_set, flush_sel;
  logic             pc_write, ifid_write, bubble;
  logic [31:0]      pc, ifid_instr, ifid_pc4;
  logic             ifid_valid, timeout;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_nxt  = state;
    warm_nxt   = warm_cnt;
    scnt_nxt   = scnt;
    to_set     = 1'b0;
    flush_sel  = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    case (state)
      WARM: begin
        // hazard inputs are not trusted yet; only redirects are obeyed
        flush_sel = bus.FlushReq;
        if (warm_cnt == '0) state_nxt = RUN;
        else                warm_nxt  = warm_cnt - 1'b1;
      end
      default: begin
        if (bus.FlushReq) begin
          flush_sel = 1'b1;
          state_nxt = RUN;
          scnt_nxt  = '0;
        end else if (bus.StallReq) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          state_nxt  = STALL;
          if (scnt == SCW'(MAX_STALL)) to_set   = 1'b1;
          else                         scnt_nxt = scnt + 1'b1;
        end else begin
          state_nxt = RUN;
          scnt_nxt  = '0;
        end
      end
    endcase
    if (!Rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= (WARMUP_CYCLES == 0) ? RUN : WARM;
      warm_cnt   <= WW'(WINIT);
      scnt       <= '0;
      timeout    <= 1'b0;
      pc         <= PC_RESET;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_nxt;
      scnt     <= scnt_nxt;
      timeout  <= timeout | to_set;
      if (flush_sel) begin
        pc         <= bus.BranchTarget;
        ifid_instr <= '0;
        ifid_pc4   <= pc_plus4;
        ifid_valid <= 1'b0;
      end else if (pc_write) begin
        pc         <= pc_plus4;
        ifid_instr <= bus.InstrIn;
        ifid_pc4   <= pc_plus4;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                      perf_cnt <= '0;
    else if (bubble && state != WARM) perf_cnt <= perf_cnt + 32'd1;
  end
  assign bus.StallCount = perf_cnt;
`else
  assign bus.StallCount = 32'h0;
`endif

  assign bus.PCOut        = pc;
  assign bus.IFIDInstr    = ifid_instr;
  assign bus.IFIDPCPlus4  = ifid_pc4;
  assign bus.IFIDValid    = ifid_valid;
  assign bus.PCWrite      = pc_write;
  assign bus.IFIDWrite    = ifid_write;
  assign bus.BubbleOut    = bubble;
  assign bus.StallTimeout = timeout;
endmodule

// File: tb/tb_fetch_stall_unit.sv
// Randomized bench for fetch_stall_unit against a cycle-level behavioural model
// with directed scenarios pinning key values.
module tb_fetch_stall_unit;
  localparam int          WARM = 4;
  localparam logic [31:0] PCR  = 32'h0000_0000;
  localparam int          MAXS = 15;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  fetch_stall_unit_if bus();

  fetch_stall_unit #(.WARMUP_CYCLES(WARM), .PC_RESET(PCR), .MAX_STALL(MAXS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign bus.InstrIn = imem(bus.PCOut);

  int total = 0;
  int bad = 0;

  // model state: plain counts of elapsed cycles rather than any encoded FSM
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_to;
  int          m_warm_done, m_consec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = PCR; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_warm_done = 0; m_consec = 0; m_to = 0; m_cnt = 0;
  endtask

  function automatic logic [2:0] exp_ctl(); // {PCWrite, IFIDWrite, BubbleOut}
    if (!Rst_n)                 return 3'b001;
    if (m_warm_done < WARM)     return 3'b110;
    if (bus.FlushReq)           return 3'b110;
    if (bus.StallReq)           return 3'b001;
    return 3'b110;
  endfunction

  task automatic model_step();
    logic [31:0] pc4;
    if (!Rst_n) return;
    pc4 = m_pc + 32'd4;
    if (m_warm_done < WARM) begin
      m_warm_done++;
      if (bus.FlushReq) begin m_pc4 = pc4; m_pc = bus.BranchTarget; m_instr = 0; m_valid = 0; end
      else begin m_instr = imem(m_pc); m_pc4 = pc4; m_pc = pc4; m_valid = 1; end
    end else if (bus.FlushReq) begin
      m_pc4 = pc4; m_pc = bus.BranchTarget; m_instr = 0; m_valid = 0; m_consec = 0;
    end else if (bus.StallReq) begin
      if (m_consec >= MAXS) m_to = 1;
      m_consec++;
`ifdef STALL_PERF_EN
      m_cnt = m_cnt + 32'd1;
`endif
    end else begin
      m_instr = imem(m_pc); m_pc4 = pc4; m_pc = pc4; m_valid = 1; m_consec = 0;
    end
  endtask

  task automatic compare_all();
    logic [2:0] c;
    c = exp_ctl();
    chk("pc",      bus.PCOut, m_pc);
    chk("instr",   bus.IFIDInstr, m_instr);
    chk("pc4",     bus.IFIDPCPlus4, m_pc4);
    chk("valid",   {31'b0, bus.IFIDValid}, {31'b0, m_valid});
    chk("ctl",     {29'b0, bus.PCWrite, bus.IFIDWrite, bus.BubbleOut}, {29'b0, c});
    chk("timeout", {31'b0, bus.StallTimeout}, {31'b0, m_to});
    chk("count",   bus.StallCount, m_cnt);
  endtask

  task automatic set_in(input logic s, input logic f, input logic [31:0] t);
    bus.StallReq = s; bus.FlushReq = f; bus.BranchTarget = t;
    #1;
  endtask

  // one clock: full compare mid-cycle, then edge with model update
  task automatic step();
    @(negedge Clk);
    compare_all();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", bus.PCOut, PCR);
    chk("rst_bubble", {31'b0, bus.BubbleOut}, 32'd1);
    chk("rst_to", {31'b0, bus.StallTimeout}, 32'd0);
    for (int i = 0; i < cycles; i++) step();
    Rst_n = 1'b1;
    #1;
  endtask

  logic [31:0] saved, p;

  initial begin
    set_in(1'b0, 1'b0, 32'h0);
    // reset then warm-up with StallReq held high
    set_in(1'b1, 1'b0, 32'h0);
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      chk("warm_pc", bus.PCOut, 32'(i * 4));
      step();
    end
    chk("post_warm_pc", bus.PCOut, 32'd16);
    chk("post_warm_bubble", {31'b0, bus.BubbleOut}, 32'd1);
    step();
    chk("post_warm_hold", bus.PCOut, 32'd16);

    // single load-use stall at 0x40
    set_in(1'b0, 1'b1, 32'h40);
    step();
    chk("redirect_40", bus.PCOut, 32'h40);
    set_in(1'b0, 1'b0, 32'h0);
    step();
    chk("pc_44", bus.PCOut, 32'h44);
    set_in(1'b0, 1'b1, 32'h40);
    step();
    saved = bus.IFIDInstr;
    set_in(1'b1, 1'b0, 32'h0);
    chk("ls_bubble", {31'b0, bus.BubbleOut}, 32'd1);
    step();
    chk("ls_hold_pc", bus.PCOut, 32'h40);
    chk("ls_hold_instr", bus.IFIDInstr, saved);
    set_in(1'b0, 1'b0, 32'h0);
    chk("ls_bubble_once", {31'b0, bus.BubbleOut}, 32'd0);
    step();
    chk("ls_resume", bus.PCOut, 32'h44);
    chk("ls_latched", bus.IFIDInstr, imem(32'h40));

    // flush beats stall
    set_in(1'b1, 1'b1, 32'h100);
    chk("fs_bubble", {31'b0, bus.BubbleOut}, 32'd0);
    step();
    chk("fs_pc", bus.PCOut, 32'h100);
    chk("fs_valid", {31'b0, bus.IFIDValid}, 32'd0);
    chk("fs_instr", bus.IFIDInstr, 32'd0);

    // PC wrap
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    set_in(1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc", bus.PCOut, 32'h0);

    // timeout after 16 consecutive stalls
    set_in(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) step();
    chk("to_not_yet", {31'b0, bus.StallTimeout}, 32'd0);
    step();
    chk("to_set", {31'b0, bus.StallTimeout}, 32'd1);
    p = bus.PCOut;
    set_in(1'b0, 1'b0, 32'h0);
    step();
    chk("to_sticky", {31'b0, bus.StallTimeout}, 32'd1);
    chk("to_resume", bus.PCOut, p + 32'd4);

    // async reset mid-stall, between edges
    set_in(1'b1, 1'b0, 32'h0);
    step();
    #2;
    do_reset(2);
    set_in(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 32'h0);
      step(); step();
      set_in(1'b0, 1'b0, 32'h0);
      step();
    end
`ifdef STALL_PERF_EN
    chk("perf_6", bus.StallCount, 32'd6);
`else
    chk("perf_0", bus.StallCount, 32'd0);
`endif

    // randomized phase
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (r < 4) begin
        set_in(1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 18; j++) step();
      end else begin
        set_in($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10, $urandom & 32'hFFFF_FFFC);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
